funnel: RTL and testbench

FUNNEL -- requirements
Module: funnel

---
 rtl/funnel.sv | 110 +++++++++++
 tb/tb_funnel.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/funnel.sv
// Round-robin N:1 funnel: one holding register per lane feeding a registered output stage.
// Optional output parity bit enabled with FUNNEL_PARITY_EN.
module funnel #(
  parameter int WIRE = 3,
  parameter int WAY  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [(2**WAY)*(2**WIRE)-1:0]    in,
  input  logic [2**WAY-1:0]                in_valid,
  output logic [2**WAY-1:0]                in_ready,
  output logic [2**WIRE-1:0]               out,
  output logic [WAY-1:0]                   out_lane,
  output logic                             out_valid,
  input  logic                             out_ready
`ifdef FUNNEL_PARITY_EN
  ,
  output logic                             out_par
`endif
);

  localparam int unsigned N = 2**WAY;
  localparam int unsigned W = 2**WIRE;

  logic [W-1:0]   hold [N];
  logic [N-1:0]   full;
  logic [N-1:0]   drain;
  logic [N-1:0]   capture;
  logic [WAY-1:0] ptr;
  logic [WAY-1:0] grant;
  logic [WAY-1:0] idx;
  logic           any_full;
  logic           load;
  logic           grant_valid;

  // First full lane at or after ptr, wrapping naturally in WAY bits.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any_full = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr + k[WAY-1:0];
      if (!any_full && full[idx]) begin
        grant    = idx;
        any_full = 1'b1;
      end
    end
  end

  assign load        = !out_valid || out_ready;
  assign grant_valid = load && any_full;

  always_comb begin
    drain = '0;
    for (int unsigned i = 0; i < N; i++) begin
      drain[i] = grant_valid && (grant == WAY'(i));
    end
  end

  // A lane being drained this cycle can accept its next word on the same edge.
  assign in_ready = rst_n ? (~full | drain) : '0;
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (capture[i]) begin
        hold[i] <= in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_lane  <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (capture[i]) begin
          full[i] <= 1'b1;
        end else if (drain[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        ptr <= grant + WAY'(1);
      end
      if (load) begin
        out_valid <= any_full;
        if (any_full) begin
          out      <= hold[grant];
          out_lane <= grant;
        end
      end
    end
  end

`ifdef FUNNEL_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (grant_valid) begin
      out_par <= ^hold[grant];
    end
  end
`endif

endmodule

// File: tb/tb_funnel.sv
// Bench for funnel (WIRE=3, WAY=2): directed vector table, hand sequences and
// randomized traffic checked against a cycle model plus a per-lane order scoreboard.
module tb_funnel;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_bus;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out;
  logic [1:0]  out_lane;
  logic        out_valid;
  logic        out_ready;
`ifdef FUNNEL_PARITY_EN
  logic        out_par;
`endif

  funnel #(.WIRE(3), .WAY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_bus),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_lane  (out_lane),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FUNNEL_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: per-lane holding slot, output word, rotating start lane.
  bit       mfull [4];
  bit [7:0] mhold [4];
  bit       mov;
  bit [7:0] mout;
  int       mlane;
  int       mptr;
  // Arrival-order scoreboard entries: lane*256 + data.
  int       sbq [$];
  logic [3:0] rdy_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic consume(input int lane, input int data);
    int found;
    found = 0;
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i] / 256 == lane) begin
        chk("sb_order", data, sbq[i] % 256);
        sbq.delete(i);
        found = 1;
        break;
      end
    end
    chk("sb_present", found, 1);
  endtask

  task automatic step(input bit r, input logic [3:0] v, input logic [31:0] d, input bit o);
    int   g;
    int   idx;
    bit   ld;
    bit   gv;
    logic [3:0] erdy;
    rst_n     = r;
    in_valid  = v;
    in_bus    = d;
    out_ready = o;
    #1;
    ld = !mov || o;
    g  = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (mptr + k) % 4;
      if (g < 0 && mfull[idx]) g = idx;
    end
    gv = ld && (g >= 0);
    for (int i = 0; i < 4; i++) erdy[i] = r && (!mfull[i] || (gv && g == i));
    rdy_seen = in_ready;
    chk("in_ready", int'(in_ready), int'(erdy));
    if (r && out_valid && o) consume(int'(out_lane), int'(out));
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < 4; i++) mfull[i] = 0;
      mov = 0; mout = 0; mlane = 0; mptr = 0;
      sbq.delete();
    end else begin
      if (ld) begin
        mov = (g >= 0);
        if (g >= 0) begin
          mout  = mhold[g];
          mlane = g;
        end
      end
      if (gv) mptr = (g + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && erdy[i]) begin
          mfull[i] = 1;
          mhold[i] = d[i*8 +: 8];
          sbq.push_back(i * 256 + int'(d[i*8 +: 8]));
        end else if (gv && g == i) begin
          mfull[i] = 0;
        end
      end
    end
    chk("out_valid", int'(out_valid), int'(mov));
    chk("out", int'(out), int'(mout));
    chk("out_lane", int'(out_lane), mlane);
`ifdef FUNNEL_PARITY_EN
    chk("out_par", int'(out_par), int'(^mout));
`endif
  endtask

  typedef struct {
    bit         r;
    logic [3:0] v;
    logic [31:0] d;
    bit         o;
    logic [3:0] rdy;
    bit         ov;
    logic [7:0] ot;
    int         lane;
    bit         par;
  } vec_t;

  vec_t tbl [9];

  initial begin
    for (int i = 0; i < 4; i++) begin
      mfull[i] = 0;
      mhold[i] = 0;
    end
    mov = 0; mout = 0; mlane = 0; mptr = 0;
    rst_n = 0; in_valid = 0; in_bus = 0; out_ready = 0;

    // Single word from lane 0, then a simultaneous pair from lanes 0 and 1.
    tbl[0] = '{0, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0, 0};
    tbl[1] = '{1, 4'b0001, 32'h0000_00BB, 1, 4'b1111, 0, 8'h00, 0, 0};
    tbl[2] = '{1, 4'b0000, 32'h0000_0000, 1, 4'b1111, 1, 8'hBB, 0, 0};
    tbl[3] = '{1, 4'b0000, 32'h0000_0000, 1, 4'b1111, 0, 8'hBB, 0, 0};
    tbl[4] = '{0, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0, 0};
    tbl[5] = '{1, 4'b0011, 32'h0000_CBBB, 1, 4'b1111, 0, 8'h00, 0, 0};
    tbl[6] = '{1, 4'b0000, 32'h0000_0000, 1, 4'b1101, 1, 8'hBB, 0, 0};
    tbl[7] = '{1, 4'b0000, 32'h0000_0000, 1, 4'b1111, 1, 8'hCB, 1, 1};
    tbl[8] = '{1, 4'b0000, 32'h0000_0000, 1, 4'b1111, 0, 8'hCB, 1, 1};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].o);
      chk("tbl_in_ready", int'(rdy_seen), int'(tbl[i].rdy));
      chk("tbl_out_valid", int'(out_valid), int'(tbl[i].ov));
      chk("tbl_out", int'(out), int'(tbl[i].ot));
      chk("tbl_out_lane", int'(out_lane), tbl[i].lane);
`ifdef FUNNEL_PARITY_EN
      chk("tbl_out_par", int'(out_par), int'(tbl[i].par));
`endif
    end

    // Backpressure: all lanes offer while the sink stalls, then drain.
    step(0, 4'h0, 32'h0, 1);
    step(1, 4'hF, 32'h281E_140A, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'hF, 32'h281E_1432, 0);
      chk("bp_hold_out", int'(out), 10);
      chk("bp_hold_valid", int'(out_valid), 1);
      if (i > 0) chk("bp_in_ready", int'(rdy_seen), 0);
    end
    begin
      int exp_lane [4] = '{1, 2, 3, 0};
      int exp_data [4] = '{20, 30, 40, 50};
      for (int i = 0; i < 4; i++) begin
        step(1, 4'h0, 32'h0, 1);
        chk("bp_drain_lane", int'(out_lane), exp_lane[i]);
        chk("bp_drain_data", int'(out), exp_data[i]);
      end
    end
    step(1, 4'h0, 32'h0, 1);
    chk("bp_empty", int'(out_valid), 0);

    // Streaming on lane 3: output stays valid every cycle, order kept.
    step(0, 4'h0, 32'h0, 1);
    for (int j = 0; j < 8; j++) begin
      step(1, 4'h8, {8'(100 + j), 24'h0}, 1);
      if (j > 0) begin
        chk("st_valid", int'(out_valid), 1);
        chk("st_data", int'(out), 100 + j - 1);
        chk("st_lane", int'(out_lane), 3);
      end
    end
    step(1, 4'h0, 32'h0, 1);
    chk("st_last", int'(out), 107);
    step(1, 4'h0, 32'h0, 1);
    chk("st_idle", int'(out_valid), 0);

    // Reset with three lanes full and a word parked on the output.
    step(1, 4'b0111, 32'h0033_2211, 0);
    step(1, 4'b0111, 32'h0033_2211, 0);
    chk("rm_pre_valid", int'(out_valid), 1);
    step(0, 4'b0111, 32'h0033_2211, 0);
    chk("rm_rdy_in_reset", int'(rdy_seen), 0);
    chk("rm_valid_after", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'h0, 32'h0, 1);
      chk("rm_no_stale", int'(out_valid), 0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) != 0, 4'($urandom), $urandom, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) step(1, 4'h0, 32'h0, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
